// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: shares one combinational integer square-root unit among
// NUM_REQ requesters. The IDLE/CALC/HOLD controller grants one requester at a time
// and holds each result until the consumer accepts it.
// Compile-time option: define SQRT_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest index wins. The default build uses round-robin arbitration.

// Combinational digit-by-digit square root: root = floor(sqrt(radical)),
// rem = radical - root^2.
module sqrt_arbiter_sqrt #(
    parameter int q_port_width = 11,
    parameter int r_port_width = 12,
    parameter int width        = 21
) (
    input  logic [width-1:0]        radical,
    output logic [q_port_width-1:0] root,
    output logic [r_port_width-1:0] rem
);
    localparam int XW = 2 * q_port_width;

    logic [XW-1:0]           x;
    logic [XW+1:0]           r;
    logic [XW+1:0]           t;
    logic [q_port_width-1:0] q;

    // One root bit per radical bit pair, from the MSB pair down.
    always_comb begin
        x = '0;
        x[width-1:0] = radical;
        r = '0;
        t = '0;
        q = '0;
        for (int i = q_port_width - 1; i >= 0; i--) begin
            r = {r[XW-1:0], x[2*i +: 2]};
            t = {{(XW - q_port_width){1'b0}}, q, 2'b01};
            if (r >= t) begin
                r = r - t;
                q = {q[q_port_width-2:0], 1'b1};
            end else begin
                q = {q[q_port_width-2:0], 1'b0};
            end
        end
        root = q;
        rem  = r[r_port_width-1:0];
    end
endmodule

module sqrt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 21,
    parameter int Q_WIDTH = 11,
    parameter int R_WIDTH = 12
) (
    input  logic                       clk_main,
    input  logic                       sys_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic [Q_WIDTH-1:0]         res_q,
    output logic [R_WIDTH-1:0]         res_rem,
    output logic                       busy
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rad_q, rad_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               res_valid_q, res_valid_d;
    logic [IDW-1:0]     res_id_q, res_id_d;
    logic [Q_WIDTH-1:0] res_q_q, res_q_d;
    logic [R_WIDTH-1:0] res_rem_q, res_rem_d;
`ifndef SQRT_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [IDW-1:0]     rr_idx;
`endif

    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic               grant_open;
    logic               grant_fire;
    logic [WIDTH-1:0]   grant_rad;
    logic [Q_WIDTH-1:0] sq_root;
    logic [R_WIDTH-1:0] sq_rem;

`ifdef SQRT_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-indexed valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[k]) begin
                win_found = 1'b1;
                win_id    = IDW'(k);
            end
        end
    end
`else
    // Round-robin: search starts just after the last granted requester and wraps.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = IDW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && req_valid[rr_idx]) begin
                win_found = 1'b1;
                win_id    = rr_idx;
            end
        end
    end
`endif

    // Grant window: IDLE, or HOLD while the held result is being consumed.
    assign grant_open = !sys_rst &&
                        ((state_q == IDLE) || ((state_q == HOLD) && res_ready));
    assign grant_fire = grant_open && win_found;

    // One-hot accept strobe and the winner's radical. Non-winning lanes are never selected.
    always_comb begin
        req_ready = '0;
        grant_rad = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == IDW'(i)) begin
                req_ready[i] = grant_fire;
                grant_rad    = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    sqrt_arbiter_sqrt #(
        .q_port_width (Q_WIDTH),
        .r_port_width (R_WIDTH),
        .width        (WIDTH)
    ) u_sqrt (
        .radical (rad_q),
        .root    (sq_root),
        .rem     (sq_rem)
    );

    // Next-state logic for the controller and the latched request.
    always_comb begin
        state_d      = state_q;
        rad_d        = rad_q;
        id_d         = id_q;
        res_valid_d  = res_valid_q;
        res_id_d     = res_id_q;
        res_q_d      = res_q_q;
        res_rem_d    = res_rem_q;
`ifndef SQRT_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                res_valid_d = 1'b1;
                res_id_d    = id_q;
                res_q_d     = sq_root;
                res_rem_d   = sq_rem;
                state_d     = HOLD;
            end
            HOLD: begin
                // An accepted result is retired. A new grant in the same cycle goes straight to CALC.
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = grant_fire ? CALC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_fire) begin
            rad_d        = grant_rad;
            id_d         = win_id;
`ifndef SQRT_ARB_FIXED_PRIO_EN
            last_grant_d = win_id;
`endif
        end
    end

    // Controller and result registers. Reset discards anything in flight.
    always_ff @(posedge clk_main) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_q_q      <= '0;
            res_rem_q    <= '0;
`ifndef SQRT_ARB_FIXED_PRIO_EN
            last_grant_q <= IDW'(NUM_REQ - 1);
`endif
        end else begin
            state_q      <= state_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_q_q      <= res_q_d;
            res_rem_q    <= res_rem_d;
`ifndef SQRT_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Latched radical and owner. These are only meaningful after a grant, so they have no reset.
    always_ff @(posedge clk_main) begin
        rad_q <= rad_d;
        id_q  <= id_d;
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_q     = res_q_q;
    assign res_rem   = res_rem_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sqrt_arbiter;
    localparam int N  = 4;
    localparam int W  = 21;
    localparam int QW = 11;
    localparam int RW = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [1:0]      res_id;
    logic [QW-1:0]   res_q;
    logic [RW-1:0]   res_rem;
    logic            busy;

    int unsigned rads [N];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {int id; int q; int r; int cyc;} res_t;
    res_t res_log[$];
    int   grant_log[$];

    sqrt_arbiter #(.NUM_REQ(N), .WIDTH(W), .Q_WIDTH(QW), .R_WIDTH(RW)) dut (
        .clk_main  (clk),
        .sys_rst   (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_q     (res_q),
        .res_rem   (res_rem),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = rads[i][W-1:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int isqrt(input int v);
        int q = 0;
        while ((q + 1) * (q + 1) <= v) q++;
        return q;
    endfunction

    // ---------------- behavioural model ----------------
    bit started = 0;
    bit m_inflight = 0;
    bit m_vis = 0;
    int m_last = N - 1;
    int pend_id, pend_q, pend_r;
    int vis_id, vis_q, vis_r;
    int cyc = 0;

    function automatic int pick();
`ifdef SQRT_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (req_valid[k]) return k;
`else
        for (int k = 1; k <= N; k++) if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
`endif
        return -1;
    endfunction

    function automatic bit can_accept();
        return !rst && !m_inflight && (!m_vis || res_ready);
    endfunction

    always @(posedge clk) begin
        int win;
        int rad;
        cyc++;
        if (rst) begin
            started    = 1;
            m_inflight = 0;
            m_vis      = 0;
            m_last     = N - 1;
        end else if (started) begin
            win = pick();
            if (can_accept() && win >= 0) begin
                if (m_vis) m_vis = 0;
                m_inflight = 1;
                pend_id = win;
                rad     = int'(rads[win]);
                pend_q  = isqrt(rad);
                pend_r  = rad - pend_q * pend_q;
                m_last  = win;
            end else if (m_inflight) begin
                m_inflight = 0;
                m_vis  = 1;
                vis_id = pend_id;
                vis_q  = pend_q;
                vis_r  = pend_r;
            end else if (m_vis && res_ready) begin
                m_vis = 0;
            end
        end
    end

    // Compare process: outputs vs model, every cycle after the first reset edge.
    always @(negedge clk) begin
        int win;
        logic [31:0] exp_rr;
        if (started) begin
            win = pick();
            exp_rr = (can_accept() && win >= 0) ? (32'd1 << win) : 32'd0;
            check("req_ready", 32'(req_ready), exp_rr);
            check("res_valid", 32'(res_valid), 32'(m_vis));
            check("busy", 32'(busy), 32'(m_inflight || m_vis));
            if (m_vis) begin
                check("res_id", 32'(res_id), vis_id);
                check("res_q", 32'(res_q), vis_q);
                check("res_rem", 32'(res_rem), vis_r);
            end
        end
    end

    // Transaction logger used by the directed checks.
    always @(negedge clk) begin
        res_t r;
        if (started && !rst) begin
            for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
            if (res_valid && res_ready) begin
                r.id = int'(res_id); r.q = int'(res_q); r.r = int'(res_rem); r.cyc = cyc;
                res_log.push_back(r);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        int exp_q[4];
        int exp_r[4];
        int exp_g[5];
        exp_q = '{3, 2, 0, 1448};
        exp_r = '{3, 0, 0, 447};
        exp_g = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) rads[i] = 0;

        // Hand-computed pins on the model's arithmetic.
        check("model_isqrt_3", isqrt(3), 1);
        check("model_isqrt_12", isqrt(12), 3);
        check("model_isqrt_max", isqrt(2097151), 1448);
        check("model_rem_max", 2097151 - 1448 * 1448, 447);

        // Reset: requests are gated while reset is high.
        req_valid = 4'b1111;
        tick(2);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_res_id", 32'(res_id), 0);
        check("rst_res_q", 32'(res_q), 0);
        check("rst_res_rem", 32'(res_rem), 0);
        req_valid = '0;
        rst = 1'b0;
        tick(2);

        // Single request. Radical 3 goes to requester 0; other lanes carry junk.
        rads[0] = 3; rads[1] = 1000; rads[2] = 2000000; rads[3] = 77;
        req_valid = 4'b0001;
        res_ready = 1'b1;
        #1;
        check("single_grant", 32'(req_ready), 1);
        tick(1);
        req_valid = '0;
        check("single_calc_valid", 32'(res_valid), 0);
        tick(1);
        check("single_valid", 32'(res_valid), 1);
        check("single_id", 32'(res_id), 0);
        check("single_q", 32'(res_q), 1);
        check("single_rem", 32'(res_rem), 2);
        tick(1);
        check("single_retired", 32'(res_valid), 0);
        check("single_idle", 32'(busy), 0);
        tick(2);

        // All four requesters busy, consumer always ready.
        do_reset();
        grant_log.delete(); res_log.delete();
        rads[0] = 12; rads[1] = 4; rads[2] = 0; rads[3] = 2097151;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        tick(10);
        req_valid = '0;
        tick(4);
        check("rr_grant_count", 32'(grant_log.size() >= 5), 1);
        check("rr_res_count", 32'(res_log.size() >= 4), 1);
        if (grant_log.size() >= 5 && res_log.size() >= 4) begin
            for (int i = 0; i < 5; i++) check($sformatf("rr_grant%0d", i), grant_log[i], exp_g[i]);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr_id%0d", i), res_log[i].id, i);
                check($sformatf("rr_q%0d", i), res_log[i].q, exp_q[i]);
                check($sformatf("rr_rem%0d", i), res_log[i].r, exp_r[i]);
            end
            for (int i = 1; i < 4; i++)
                check($sformatf("rr_spacing%0d", i), res_log[i].cyc - res_log[i-1].cyc, 2);
        end

        // Backpressure: the held result must stay put while res_ready is low.
        do_reset();
        req_valid = 4'b1111;
        res_ready = 1'b0;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(res_valid), 1);
            check("bp_id", 32'(res_id), 0);
            check("bp_q", 32'(res_q), 3);
            check("bp_rem", 32'(res_rem), 3);
            check("bp_no_grant", 32'(req_ready), 0);
            tick(1);
        end
        res_ready = 1'b1;
        #1;
        check("bp_next_grant", 32'(req_ready), 2);
        tick(1);
        req_valid = '0;
        tick(4);

        // Reset during CALC discards the in-flight result.
        grant_log.delete(); res_log.delete();
        req_valid = 4'b0100;
        #1;
        check("mid_grant", 32'(req_ready), 4);
        tick(1);
        req_valid = '0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_valid", 32'(res_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        tick(1);
        check("mid_no_emit", 32'(res_valid), 0);
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        check("mid_first_grant", 32'(req_ready), 1);
        tick(1);
        req_valid = '0;
        tick(4);
        check("mid_res_count", res_log.size(), 1);
        if (res_log.size() >= 1) check("mid_res_owner", res_log[0].id, 0);

        // Two requesters held: fixed priority vs. round-robin alternation.
        do_reset();
        grant_log.delete(); res_log.delete();
        req_valid = 4'b1010;
        res_ready = 1'b1;
        tick(8);
        req_valid = '0;
        tick(4);
        check("pair_grant_count", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size(); i++) begin
`ifdef SQRT_ARB_FIXED_PRIO_EN
            check($sformatf("fixed_grant%0d", i), grant_log[i], 1);
`else
            check($sformatf("rr_pair_grant%0d", i), grant_log[i], (i % 2 == 0) ? 1 : 3);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
